// File: rtl/adt7420_poll_ctrl.sv
// ADT7420 sequencer: programs the threshold registers once, then polls the temperature over a shared I2C command port.
// Build option: define ADT7420_CRIT_EN to program T_CRIT (register 0x08) and drive the crit flag.
module adt7420_poll_ctrl #(
   parameter int unsigned SYS_FREQ    = 40000000,
   parameter int unsigned POLL_CYCLES = 400000,
   parameter logic [6:0]  DEV_ADDR    = 7'h48,
   parameter logic [15:0] T_HIGH      = 16'h2000,
   parameter logic [15:0] T_LOW       = 16'h0500,
   parameter logic [15:0] T_CRIT      = 16'h4980,
   parameter int unsigned MAX_RETRY   = 2,
   parameter int unsigned TIMEOUT     = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        i2c_req,
   output logic        i2c_rw,
   output logic [6:0]  i2c_dev_addr,
   output logic [7:0]  i2c_reg_addr,
   output logic [15:0] i2c_wdata,
   output logic [1:0]  i2c_nbytes,
   input  logic        i2c_done,
   input  logic        i2c_ack_err,
   input  logic [15:0] i2c_rdata,
   output logic [12:0] temp,
   output logic        temp_valid,
   output logic        alarm_high,
   output logic        alarm_low,
   output logic        crit,
   output logic        init_done,
   output logic [7:0]  err_cnt
);

   // SYS_FREQ is informational; a nonsensical setup falls back to the shortest legal interval
   localparam int unsigned POLL_LOAD = (POLL_CYCLES < 2 || SYS_FREQ == 0) ? 1 : POLL_CYCLES - 1;
   localparam int unsigned TMR_W     = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
   localparam int unsigned TO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned TO_LAST   = (TIMEOUT > 1) ? TIMEOUT - 1 : 1;
   localparam int unsigned RTY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic signed [12:0] TH_HIGH = T_HIGH[15:3];
   localparam logic signed [12:0] TH_LOW  = T_LOW[15:3];

   typedef enum logic [2:0] {
      IDLE,
      CFG_HIGH,
      CFG_LOW,
      CFG_CRIT,
      WAIT_TMR,
      RD_TEMP,
      EVAL
   } state_t;

   state_t             state_q, state_d;
   logic               req_q, req_d;
   logic               rw_q, rw_d;
   logic [7:0]         reg_q, reg_d;
   logic [15:0]        wdata_q, wdata_d;
   logic [12:0]        temp_q, temp_d;
   logic               temp_valid_q, temp_valid_d;
   logic               ahigh_q, ahigh_d;
   logic               alow_q, alow_d;
   logic               init_q, init_d;
   logic [7:0]         err_q, err_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic [RTY_W-1:0]   rty_q, rty_d;

   logic               xfer_ok;
   logic               xfer_fail;
   logic signed [12:0] rd_temp;
   logic               unused_rdata_lsbs;

   assign rd_temp           = i2c_rdata[15:3];
   assign unused_rdata_lsbs = ^i2c_rdata[2:0];

   // Completion is only honoured while a request is outstanding
   assign xfer_ok   = req_q & i2c_done & ~i2c_ack_err;
   assign xfer_fail = req_q & ((i2c_done & i2c_ack_err) |
                               (~i2c_done & (to_q == TO_W'(TO_LAST))));

`ifdef ADT7420_CRIT_EN
   localparam logic signed [12:0] TH_CRIT = T_CRIT[15:3];
   logic crit_q, crit_d;
`endif

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      rw_d         = rw_q;
      reg_d        = reg_q;
      wdata_d      = wdata_q;
      temp_d       = temp_q;
      temp_valid_d = 1'b0;
      ahigh_d      = ahigh_q;
      alow_d       = alow_q;
`ifdef ADT7420_CRIT_EN
      crit_d       = crit_q;
`endif
      init_d       = init_q;
      err_d        = err_q;
      rty_d        = rty_q;
      tmr_d        = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
      to_d         = req_q ? to_q + TO_W'(1) : '0;

      case (state_q)
         IDLE: begin
            if (enable) state_d = init_q ? WAIT_TMR : CFG_HIGH;
         end
         WAIT_TMR: begin
            if (!enable)           state_d = IDLE;
            else if (tmr_q == '0)  state_d = init_q ? RD_TEMP : CFG_HIGH;
         end
         EVAL: begin
            state_d = enable ? WAIT_TMR : IDLE;
         end
         default: begin
            // Transfer states: req is re-raised one cycle after a drop (done, NACK or timeout)
            if (!req_q) begin
               if (!enable) state_d = IDLE;
               else         req_d   = 1'b1;
            end else if (xfer_ok) begin
               req_d = 1'b0;
               case (state_q)
                  CFG_HIGH: state_d = CFG_LOW;
                  CFG_LOW: begin
`ifdef ADT7420_CRIT_EN
                     state_d = CFG_CRIT;
`else
                     state_d = WAIT_TMR;
                     init_d  = 1'b1;
`endif
                  end
                  CFG_CRIT: begin
                     state_d = WAIT_TMR;
                     init_d  = 1'b1;
                  end
                  default: begin
                     state_d      = EVAL;
                     temp_d       = rd_temp;
                     temp_valid_d = 1'b1;
                     ahigh_d      = (rd_temp >= TH_HIGH);
                     alow_d       = (rd_temp <= TH_LOW);
`ifdef ADT7420_CRIT_EN
                     crit_d       = (rd_temp >= TH_CRIT);
`endif
                  end
               endcase
               if (!enable && state_d != EVAL) state_d = IDLE;
            end else if (xfer_fail) begin
               req_d = 1'b0;
               if (rty_q == RTY_W'(MAX_RETRY)) begin
                  if (err_q != '1) err_d = err_q + 8'd1;
                  state_d = enable ? WAIT_TMR : IDLE;
               end else if (!enable) begin
                  state_d = IDLE;
               end else begin
                  rty_d = rty_q + RTY_W'(1);
               end
            end
         end
      endcase

      // Command fields are latched on entry so they stay put for the whole request
      if (state_d != state_q) begin
         rty_d = '0;
         case (state_d)
            CFG_HIGH: begin rw_d = 1'b0; reg_d = 8'h04; wdata_d = T_HIGH; end
            CFG_LOW:  begin rw_d = 1'b0; reg_d = 8'h06; wdata_d = T_LOW;  end
            CFG_CRIT: begin rw_d = 1'b0; reg_d = 8'h08; wdata_d = T_CRIT; end
            RD_TEMP:  begin rw_d = 1'b1; reg_d = 8'h00; end
            WAIT_TMR: tmr_d = TMR_W'(POLL_LOAD);
            default: ;
         endcase
         if (state_q == IDLE || state_q == WAIT_TMR)
            req_d = (state_d == CFG_HIGH) || (state_d == RD_TEMP);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         rw_q         <= 1'b0;
         reg_q        <= '0;
         wdata_q      <= '0;
         temp_q       <= '0;
         temp_valid_q <= 1'b0;
         ahigh_q      <= 1'b0;
         alow_q       <= 1'b0;
         init_q       <= 1'b0;
         err_q        <= '0;
         tmr_q        <= '0;
         to_q         <= '0;
         rty_q        <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         rw_q         <= rw_d;
         reg_q        <= reg_d;
         wdata_q      <= wdata_d;
         temp_q       <= temp_d;
         temp_valid_q <= temp_valid_d;
         ahigh_q      <= ahigh_d;
         alow_q       <= alow_d;
         init_q       <= init_d;
         err_q        <= err_d;
         tmr_q        <= tmr_d;
         to_q         <= to_d;
         rty_q        <= rty_d;
      end
   end

`ifdef ADT7420_CRIT_EN
   always_ff @(posedge clk) begin
      if (rst) crit_q <= 1'b0;
      else     crit_q <= crit_d;
   end
   assign crit = crit_q;
`else
   assign crit = 1'b0;
`endif

   assign i2c_req      = req_q;
   assign i2c_rw       = rw_q;
   assign i2c_dev_addr = DEV_ADDR;
   assign i2c_reg_addr = reg_q;
   assign i2c_wdata    = wdata_q;
   assign i2c_nbytes   = 2'd2;
   assign temp         = temp_q;
   assign temp_valid   = temp_valid_q;
   assign alarm_high   = ahigh_q;
   assign alarm_low    = alow_q;
   assign init_done    = init_q;
   assign err_cnt      = err_q;

endmodule

// File: tb/tb_adt7420_poll_ctrl.sv
// Directed bench for adt7420_poll_ctrl with a hand-driven I2C master; expectations follow ADT7420_CRIT_EN when defined.
module tb_adt7420_poll_ctrl;

   localparam int P  = 20;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        i2c_req;
   logic        i2c_rw;
   logic [6:0]  i2c_dev_addr;
   logic [7:0]  i2c_reg_addr;
   logic [15:0] i2c_wdata;
   logic [1:0]  i2c_nbytes;
   logic        i2c_done;
   logic        i2c_ack_err;
   logic [15:0] i2c_rdata;
   logic [12:0] temp;
   logic        temp_valid;
   logic        alarm_high;
   logic        alarm_low;
   logic        crit;
   logic        init_done;
   logic [7:0]  err_cnt;

`ifdef ADT7420_CRIT_EN
   localparam logic CRIT_BUILT = 1'b1;
`else
   localparam logic CRIT_BUILT = 1'b0;
`endif

   adt7420_poll_ctrl #(
      .POLL_CYCLES (P),
      .DEV_ADDR    (7'h48),
      .T_HIGH      (16'h2000),
      .T_LOW       (16'h0500),
      .T_CRIT      (16'h4980),
      .MAX_RETRY   (2),
      .TIMEOUT     (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .i2c_req      (i2c_req),
      .i2c_rw       (i2c_rw),
      .i2c_dev_addr (i2c_dev_addr),
      .i2c_reg_addr (i2c_reg_addr),
      .i2c_wdata    (i2c_wdata),
      .i2c_nbytes   (i2c_nbytes),
      .i2c_done     (i2c_done),
      .i2c_ack_err  (i2c_ack_err),
      .i2c_rdata    (i2c_rdata),
      .temp         (temp),
      .temp_valid   (temp_valid),
      .alarm_high   (alarm_high),
      .alarm_low    (alarm_low),
      .crit         (crit),
      .init_done    (init_done),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;
   int last_done = 0;
   int req_cyc = 0;
   int prev = 0;
   int n = 0;
   int seen = 0;
   int drop_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where the request is first seen
   task automatic wait_req(input string tag);
      int k = 0;
      while (i2c_req !== 1'b1 && k < 3 * P + 50) begin
         @(negedge clk);
         k++;
      end
      req_cyc = cyc;
      check({tag, "_req"}, 32'(i2c_req), 32'd1);
   endtask

   task automatic xfer(input string tag, input logic rw, input logic [7:0] ra,
                       input logic [15:0] wd, input logic nack, input logic [15:0] rd,
                       input int dly);
      wait_req(tag);
      check({tag, "_rw"},    32'(i2c_rw),       32'(rw));
      check({tag, "_reg"},   32'(i2c_reg_addr), 32'(ra));
      check({tag, "_nb"},    32'(i2c_nbytes),   32'd2);
      check({tag, "_dev"},   32'(i2c_dev_addr), 32'h48);
      if (!rw) check({tag, "_wdata"}, 32'(i2c_wdata), 32'(wd));
      repeat (dly) begin
         @(negedge clk);
         check({tag, "_hold"}, {i2c_req, i2c_reg_addr}, {1'b1, ra});
      end
      i2c_done    = 1'b1;
      i2c_ack_err = nack;
      i2c_rdata   = rd;
      @(negedge clk);
      i2c_done    = 1'b0;
      i2c_ack_err = 1'b0;
      i2c_rdata   = 16'hDEAD;
      last_done   = cyc;
      check({tag, "_drop"}, 32'(i2c_req), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      enable      = 1'b0;
      i2c_done    = 1'b0;
      i2c_ack_err = 1'b0;
      i2c_rdata   = 16'h0000;
      repeat (3) @(negedge clk);

      check("rst_req",   32'(i2c_req),      32'd0);
      check("rst_rw",    32'(i2c_rw),       32'd0);
      check("rst_tv",    32'(temp_valid),   32'd0);
      check("rst_flags", {alarm_high, alarm_low, crit}, 32'd0);
      check("rst_init",  32'(init_done),    32'd0);
      check("rst_temp",  32'(temp),         32'd0);
      check("rst_err",   32'(err_cnt),      32'd0);
      check("rst_reg",   32'(i2c_reg_addr), 32'd0);
      check("rst_wdata", 32'(i2c_wdata),    32'd0);
      check("rst_nb",    32'(i2c_nbytes),   32'd2);
      check("rst_dev",   32'(i2c_dev_addr), 32'h48);

      rst = 1'b0;
      @(negedge clk);
      check("idle_req", 32'(i2c_req), 32'd0);
      enable = 1'b1;

      // Register 0x06 NACKs on every attempt: first try plus two retries
      xfer("cfg_high", 1'b0, 8'h04, 16'h2000, 1'b0, 16'h0, 1);
      prev = last_done;
      xfer("cfg_low0", 1'b0, 8'h06, 16'h0500, 1'b1, 16'h0, 0);
      check("gap_low0", 32'(req_cyc - prev), 32'd1);
      prev = last_done;
      xfer("cfg_low1", 1'b0, 8'h06, 16'h0500, 1'b1, 16'h0, 2);
      check("gap_low1", 32'(req_cyc - prev), 32'd1);
      prev = last_done;
      xfer("cfg_low2", 1'b0, 8'h06, 16'h0500, 1'b1, 16'h0, 0);
      check("gap_low2", 32'(req_cyc - prev), 32'd1);
      check("cfg_fail_err",  32'(err_cnt),   32'd1);
      check("cfg_fail_init", 32'(init_done), 32'd0);

      prev = last_done;
      xfer("cfg_high_r", 1'b0, 8'h04, 16'h2000, 1'b0, 16'h0, 0);
      check("gap_cfg_restart", 32'(req_cyc - prev), 32'(P));
      xfer("cfg_low_r", 1'b0, 8'h06, 16'h0500, 1'b0, 16'h0, 1);
`ifdef ADT7420_CRIT_EN
      xfer("cfg_crit", 1'b0, 8'h08, 16'h4980, 1'b0, 16'h0, 1);
`endif
      check("init_set", 32'(init_done), 32'd1);
      prev = last_done;

      xfer("rd1", 1'b1, 8'h00, 16'h0, 1'b0, 16'h0C80, 2);
      check("gap_rd1",  32'(req_cyc - prev), 32'(P));
      check("rd1_tv",   32'(temp_valid), 32'd1);
      check("rd1_temp", 32'(temp), 32'h190);
      check("rd1_flags", {alarm_high, alarm_low, crit}, 32'b000);
      @(negedge clk);
      check("rd1_tv_pulse", 32'(temp_valid), 32'd0);
      prev = last_done;

      xfer("rd2", 1'b1, 8'h00, 16'h0, 1'b0, 16'hE480, 1);
      check("gap_rd2",  32'(req_cyc - prev), 32'(P + 1));
      check("rd2_temp", 32'(temp), 32'h1C90);
      check("rd2_flags", {alarm_high, alarm_low, crit}, 32'b010);

      xfer("rd3", 1'b1, 8'h00, 16'h0, 1'b0, 16'h4A00, 0);
      check("rd3_temp", 32'(temp), 32'h940);
      check("rd3_flags", {alarm_high, alarm_low, crit}, {29'd0, 1'b1, 1'b0, CRIT_BUILT});

      // Silent master: each attempt must hold req for exactly TIMEOUT clocks
      for (int a = 0; a < 3; a++) begin
         wait_req("to");
         if (a > 0) check("to_gap", 32'(req_cyc - drop_cyc), 32'd1);
         check("to_reg", 32'(i2c_reg_addr), 32'h00);
         n = 0;
         while (i2c_req === 1'b1 && n < 2 * TO) begin
            @(negedge clk);
            n++;
         end
         drop_cyc = cyc;
         check("to_len", 32'(n), 32'(TO));
      end
      check("to_err",  32'(err_cnt), 32'd2);
      check("to_temp", 32'(temp), 32'h940);
      check("to_tv",   32'(temp_valid), 32'd0);
      check("to_high", 32'(alarm_high), 32'd1);

      // Drop enable while a read is outstanding
      wait_req("rd4");
      check("gap_rd4", 32'(req_cyc - drop_cyc), 32'(P));
      enable = 1'b0;
      xfer("rd4", 1'b1, 8'h00, 16'h0, 1'b0, 16'h0C80, 2);
      check("rd4_tv",   32'(temp_valid), 32'd1);
      check("rd4_temp", 32'(temp), 32'h190);
      check("rd4_flags", {alarm_high, alarm_low, crit}, 32'b000);
      seen = 0;
      repeat (3 * P) begin
         @(negedge clk);
         if (i2c_req === 1'b1) seen++;
      end
      check("idle_no_req", 32'(seen), 32'd0);
      check("idle_init",   32'(init_done), 32'd1);

      prev = cyc;
      enable = 1'b1;
      xfer("rd5", 1'b1, 8'h00, 16'h0, 1'b0, 16'hE480, 0);
      check("gap_reenable", 32'(req_cyc - prev), 32'(P + 1));
      check("rd5_temp", 32'(temp), 32'h1C90);

      // Reset in the middle of a request
      wait_req("rd6");
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_req",  32'(i2c_req), 32'd0);
      check("mid_rst_init", 32'(init_done), 32'd0);
      check("mid_rst_temp", 32'(temp), 32'd0);
      rst = 1'b0;
      enable = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
